// File: rtl/fg_pkg.sv
// Shared widths, waveform codes and key FSM state encoding for the function
// generator parameter sequencer.
package fg_pkg;

  localparam int FREQ_W = 7;
  localparam int WAVE_W = 2;
  localparam int FTW_W  = 32;

  typedef enum logic [WAVE_W-1:0] {
    WAVE_SINE   = 2'd0,
    WAVE_SQUARE = 2'd1,
    WAVE_TRI    = 2'd2,
    WAVE_SAW    = 2'd3
  } wave_t;

  typedef enum logic [1:0] {
    KEY_IDLE = 2'd0,
    KEY_DEB  = 2'd1,
    KEY_HOLD = 2'd2,
    KEY_RPT  = 2'd3
  } key_state_t;

endpackage

// File: rtl/key_debounce_repeat.sv
// Synchronises one active-low raw key, debounces it and emits single-cycle
// press events, optionally with auto-repeat while the key is held.
module key_debounce_repeat
  import fg_pkg::*;
#(
  parameter int DEB_CYCLES = 1_000_000,
  parameter int REP_DELAY  = 25_000_000,
  parameter int REP_PERIOD = 5_000_000,
  parameter bit REP_EN     = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  output logic press_evt
);

  localparam int MAX_A  = (DEB_CYCLES > REP_DELAY) ? DEB_CYCLES : REP_DELAY;
  localparam int MAX_B  = (MAX_A > REP_PERIOD) ? MAX_A : REP_PERIOD;
  localparam int CNT_W  = $clog2(MAX_B + 1);
  localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REP_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REP_PERIOD - 1);

  logic key_meta, key_sync, pressed;
  key_state_t state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, rel_cnt, rel_nxt;
  logic evt_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_meta <= 1'b1;
      key_sync <= 1'b1;
    end else begin
      key_meta <= key_raw;
      key_sync <= key_meta;
    end
  end

  assign pressed = ~key_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= KEY_IDLE;
      cnt       <= '0;
      rel_cnt   <= '0;
      press_evt <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      rel_cnt   <= rel_nxt;
      press_evt <= evt_nxt;
    end
  end

  // cnt times the press (debounce, repeat delay, repeat period);
  // rel_cnt times a stable release out of HOLD/RPT.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rel_nxt   = '0;
    evt_nxt   = 1'b0;
    case (state)
      KEY_IDLE: begin
        if (pressed) begin
          state_nxt = KEY_DEB;
          cnt_nxt   = '0;
        end
      end
      KEY_DEB: begin
        if (!pressed) begin
          state_nxt = KEY_IDLE;
        end else if (cnt == DEB_LAST) begin
          state_nxt = KEY_HOLD;
          cnt_nxt   = '0;
          evt_nxt   = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        if (!pressed) begin
          cnt_nxt = '0;
          if (rel_cnt == DEB_LAST) state_nxt = KEY_IDLE;
          else                     rel_nxt   = rel_cnt + 1'b1;
        end else if (REP_EN && state == KEY_HOLD && cnt == DELAY_LAST) begin
          state_nxt = KEY_RPT;
          cnt_nxt   = '0;
          evt_nxt   = 1'b1;
        end else if (REP_EN && state == KEY_RPT && cnt == PERIOD_LAST) begin
          cnt_nxt = '0;
          evt_nxt = 1'b1;
        end else if (REP_EN) begin
          cnt_nxt = cnt + 1'b1;
        end
      end
    endcase
  end

endmodule

// File: rtl/fg_param_sequencer.sv
// Turns the three user keys into pending frequency/waveform settings and
// commits them to the DDS/LCD outputs only at LCD frame boundaries.
module fg_param_sequencer
  import fg_pkg::*;
#(
  parameter int          DEB_CYCLES  = 1_000_000,
  parameter int          REP_DELAY   = 25_000_000,
  parameter int          REP_PERIOD  = 5_000_000,
  parameter int          FREQ_MAX    = 99,
  parameter int          WAVE_NUM    = 4,
  parameter logic [31:0] FTW_STEP    = 32'd85899,
  parameter bit          SYNC_COMMIT = 1'b1
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              freq_up_key,
  input  logic              freq_down_key,
  input  logic              wave_form_key,
  input  logic              lcd_vs,
  output logic [FREQ_W-1:0] freq_num,
  output logic [FTW_W-1:0]  frequency,
  output logic [WAVE_W-1:0] wave_sel,
  output logic              freq_up_trigger,
  output logic              freq_down_trigger,
  output logic              param_update
);

  localparam logic [FREQ_W-1:0] FREQ_TOP  = FREQ_W'(FREQ_MAX);
  localparam logic [WAVE_W-1:0] WAVE_LAST = WAVE_W'(WAVE_NUM - 1);
  localparam logic [24:0]       STEP_25   = FTW_STEP[24:0];

  logic up_evt, down_evt, wave_evt;
  logic vs_meta, vs_sync, vs_dly, commit_en;
  logic [FREQ_W-1:0] pend_freq, pend_freq_nxt, freq_plus1;
  logic [WAVE_W-1:0] pend_wave, pend_wave_nxt;
  logic [FTW_W-1:0]  ftw_product;

  key_debounce_repeat #(
    .DEB_CYCLES(DEB_CYCLES), .REP_DELAY(REP_DELAY), .REP_PERIOD(REP_PERIOD), .REP_EN(1'b1)
  ) u_key_up (.clk(sys_clk), .rst_n(rst_n), .key_raw(freq_up_key), .press_evt(up_evt));

  key_debounce_repeat #(
    .DEB_CYCLES(DEB_CYCLES), .REP_DELAY(REP_DELAY), .REP_PERIOD(REP_PERIOD), .REP_EN(1'b1)
  ) u_key_down (.clk(sys_clk), .rst_n(rst_n), .key_raw(freq_down_key), .press_evt(down_evt));

  key_debounce_repeat #(
    .DEB_CYCLES(DEB_CYCLES), .REP_DELAY(REP_DELAY), .REP_PERIOD(REP_PERIOD), .REP_EN(1'b0)
  ) u_key_wave (.clk(sys_clk), .rst_n(rst_n), .key_raw(wave_form_key), .press_evt(wave_evt));

  // Opposing up/down events in one cycle cancel; the wave event is independent.
  always_comb begin
    pend_freq_nxt = pend_freq;
    pend_wave_nxt = pend_wave;
    if (up_evt && !down_evt && pend_freq < FREQ_TOP)
      pend_freq_nxt = pend_freq + 1'b1;
    else if (down_evt && !up_evt && pend_freq != '0)
      pend_freq_nxt = pend_freq - 1'b1;
    if (wave_evt)
      pend_wave_nxt = (pend_wave == WAVE_LAST) ? '0 : pend_wave + 1'b1;
  end

  assign commit_en   = SYNC_COMMIT ? (vs_sync & ~vs_dly) : 1'b1;
  assign freq_plus1  = pend_freq + 1'b1;
  assign ftw_product = {25'd0, freq_plus1} * {7'd0, STEP_25};

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_meta           <= 1'b0;
      vs_sync           <= 1'b0;
      vs_dly            <= 1'b0;
      pend_freq         <= '0;
      pend_wave         <= WAVE_SINE;
      freq_num          <= '0;
      frequency         <= FTW_STEP;
      wave_sel          <= WAVE_SINE;
      freq_up_trigger   <= 1'b0;
      freq_down_trigger <= 1'b0;
      param_update      <= 1'b0;
    end else begin
      vs_meta   <= lcd_vs;
      vs_sync   <= vs_meta;
      vs_dly    <= vs_sync;
      pend_freq <= pend_freq_nxt;
      pend_wave <= pend_wave_nxt;
      freq_up_trigger   <= 1'b0;
      freq_down_trigger <= 1'b0;
      param_update      <= 1'b0;
      if (commit_en) begin
        freq_num          <= pend_freq;
        frequency         <= ftw_product;
        wave_sel          <= pend_wave;
        freq_up_trigger   <= pend_freq > freq_num;
        freq_down_trigger <= pend_freq < freq_num;
        param_update      <= (pend_freq != freq_num) || (pend_wave != wave_sel);
      end
    end
  end

endmodule
